// File: rtl/la_pkg.sv
// Shared types and constants for the logic-analyser acquisition path.
// Holds the capture FSM encoding, sample width and default geometry.
package la_pkg;

  localparam int LA_SAMPLE_W = 8;
  localparam int LA_DEPTH    = 256;
  localparam int LA_DIV_W    = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } la_state_e;

endpackage

// File: rtl/sample_ram.sv
// Simple dual-port sample buffer, DEPTH x LA_SAMPLE_W, no reset.
// Ports: i_we/i_waddr/i_wdata write side; i_raddr -> o_rdata (1-cycle).
module sample_ram
  import la_pkg::*;
#(
  parameter int DEPTH = LA_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   i_we,
  input  logic [AW-1:0]          i_waddr,
  input  logic [LA_SAMPLE_W-1:0] i_wdata,
  input  logic [AW-1:0]          i_raddr,
  output logic [LA_SAMPLE_W-1:0] o_rdata
);

  logic [LA_SAMPLE_W-1:0] r_mem [DEPTH];

  // Read-before-write: a same-address collision returns the old word.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/sample_capture.sv
// Acquisition stage: probe sync, prescaler, masked trigger, capture FSM.
// Ports: grant_acq/done_acq/armed control, probe/div/trig_* in, rd_* readback.
module sample_capture
  import la_pkg::*;
#(
  parameter int DEPTH = LA_DEPTH,
  parameter int AW    = 8,
  parameter int DIV_W = LA_DIV_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   grant_acq,
  input  logic [LA_SAMPLE_W-1:0] probe,
  input  logic [DIV_W-1:0]       div,
  input  logic [LA_SAMPLE_W-1:0] trig_mask,
  input  logic [LA_SAMPLE_W-1:0] trig_value,
  output logic                   done_acq,
  output logic                   armed,
  input  logic [AW-1:0]          rd_addr,
  output logic [LA_SAMPLE_W-1:0] rd_data
);

  logic [LA_SAMPLE_W-1:0] r_sync1;
  logic [LA_SAMPLE_W-1:0] r_sync2;
  la_state_e              r_state;
  logic [DIV_W-1:0]       r_pre;
  logic [AW-1:0]          r_wr_ptr;
  logic                   r_done;
  logic                   r_armed;
  logic                   r_rd_vld;

  logic                   w_run;
  logic                   w_strobe;
  logic                   w_match;
  logic                   w_trig;
  logic                   w_we;
  logic                   w_last;
  logic [AW-1:0]          w_waddr;
  logic [LA_SAMPLE_W-1:0] w_ram_q;

  always_ff @(posedge clk) begin
    r_sync1 <= probe;
    r_sync2 <= r_sync1;
  end

  assign w_run    = grant_acq &&
                    (r_state == ST_ARM || r_state == ST_CAPTURE);
  assign w_strobe = w_run && (r_pre == '0);
  assign w_match  = ((r_sync2 ^ trig_value) & trig_mask) == '0;
  assign w_trig   = w_strobe && (r_state == ST_ARM) && w_match;
  assign w_we     = w_trig ||
                    (w_strobe && r_state == ST_CAPTURE);
  assign w_waddr  = (r_state == ST_ARM) ? '0 : r_wr_ptr;
  assign w_last   = r_wr_ptr == AW'(DEPTH - 1);

  // Held at 0 outside ARM/CAPTURE so the first ARM cycle strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre <= '0;
    end else if (!w_run) begin
      r_pre <= '0;
    end else if (w_strobe) begin
      r_pre <= div;
    end else begin
      r_pre <= r_pre - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_wr_ptr <= '0;
      r_done   <= 1'b0;
      r_armed  <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          r_wr_ptr <= '0;
          if (grant_acq) begin
            r_state <= ST_ARM;
            r_armed <= 1'b1;
          end
        end
        ST_ARM: begin
          if (!grant_acq) begin
            r_state <= ST_IDLE;
            r_armed <= 1'b0;
          end else if (w_trig) begin
            r_wr_ptr <= AW'(1);
            r_state  <= ST_CAPTURE;
            r_armed  <= 1'b0;
          end
        end
        ST_CAPTURE: begin
          if (!grant_acq) begin
            r_state <= ST_IDLE;
          end else if (w_strobe) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_last) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (!grant_acq) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // The RAM output register has no reset; this flag forces rd_data
  // to 0 from reset until the first post-reset read has completed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rd_vld <= 1'b0;
    else        r_rd_vld <= 1'b1;
  end

  sample_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (r_sync2),
    .i_raddr (rd_addr),
    .o_rdata (w_ram_q)
  );

  assign rd_data  = r_rd_vld ? w_ram_q : '0;
  assign done_acq = r_done;
  assign armed    = r_armed;

endmodule

// File: tb/tb_sample_capture.sv
// Bench for sample_capture: random/counting probe vs. a timing model.
// Model derives strobe, trigger, sample and done edges from probe history.
module tb_sample_capture;

  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int DIV_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             grant_acq = 1'b0;
  logic [7:0]       probe = 8'h00;
  logic [DIV_W-1:0] div = '0;
  logic [7:0]       trig_mask = 8'h00;
  logic [7:0]       trig_value = 8'h00;
  logic             done_acq;
  logic             armed;
  logic [AW-1:0]    rd_addr = '0;
  logic [7:0]       rd_data;

  int nvec = 0;
  int nerr = 0;
  int ecnt = 0;
  int pmode = 0;
  logic [7:0] hist [0:16383];

  always #5 clk = ~clk;

  sample_capture #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DIV_W (DIV_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .grant_acq  (grant_acq),
    .probe      (probe),
    .div        (div),
    .trig_mask  (trig_mask),
    .trig_value (trig_value),
    .done_acq   (done_acq),
    .armed      (armed),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    nvec++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock: record the probe value the DUT sampled at this edge,
  // then drive the next probe value 1 time unit later.
  task automatic tick();
    @(posedge clk);
    ecnt++;
    hist[ecnt] = probe;
    #1;
    if (pmode == 0) probe = probe + 8'd1;
    else            probe = 8'($urandom);
  endtask

  // Full capture. Model: grant seen at edge N; strobes at N+1+k*P;
  // sample used at edge e is the probe seen at edge e-2; trigger T is
  // the first matching strobe; sample a = probe@(T+a*P-2);
  // done after edge T+(DEPTH-1)*P.
  task automatic capture(input string tag, input int d,
                         input logic [7:0] m, input logic [7:0] v,
                         input int hold, input bit rst_end);
    int n, p, t, arm_fall, done_e;
    div = DIV_W'(d);
    trig_mask = m;
    trig_value = v;
    grant_acq = 1'b1;
    tick();
    n = ecnt;
    chk({tag, ".armed_on_grant"}, armed, 1);
    arm_fall = -1;
    done_e = -1;
    for (int i = 0; i < 4000; i++) begin
      tick();
      if (arm_fall < 0 && !armed) arm_fall = ecnt;
      if (done_acq) begin
        done_e = ecnt;
        break;
      end
    end
    chk({tag, ".done_seen"}, done_e >= 0, 1);
    p = d + 1;
    t = -1;
    for (int e = n + 1; e <= ecnt; e += p) begin
      if (((hist[e-2] ^ v) & m) == 8'h00) begin
        t = e;
        break;
      end
    end
    chk({tag, ".trigger_edge"}, arm_fall, t);
    chk({tag, ".done_edge"}, done_e, t + (DEPTH - 1) * p);
    if (t >= 0 && done_e >= 0) begin
      for (int a = 0; a < DEPTH; a++) begin
        rd_addr = AW'(a);
        tick();
        chk($sformatf("%s.buf[%0d]", tag, a), rd_data,
            hist[t + a * p - 2]);
      end
    end
    for (int h = 0; h < hold; h++) begin
      tick();
      chk({tag, ".done_hold"}, done_acq, 1);
    end
    if (rst_end) begin
      rst_n = 1'b0;
      #1;
      chk({tag, ".rst_done"}, done_acq, 0);
      grant_acq = 1'b0;
      #1;
      rst_n = 1'b1;
      tick();
    end else begin
      grant_acq = 1'b0;
      tick();
      chk({tag, ".done_drop"}, done_acq, 0);
    end
    chk({tag, ".armed_idle"}, armed, 0);
  endtask

  initial begin
    int n;
    bit seen;
    repeat (3) tick();
    chk("reset.done", done_acq, 0);
    chk("reset.armed", armed, 0);
    chk("reset.rd_data", rd_data, 0);
    rst_n = 1'b1;
    tick();
    chk("idle.armed", armed, 0);
    tick();

    // Immediate trigger, full rate, counting probe
    pmode = 0;
    capture("immediate", 0, 8'h00, 8'h00, 0, 1'b0);

    // Pattern trigger on high nibble A
    probe = 8'h00;
    capture("pattern", 0, 8'hF0, 8'hA0, 0, 1'b0);

    // Divider of 4
    capture("divider", 3, 8'h00, 8'h00, 0, 1'b0);

    // Handshake: hold 5 cycles, 1-cycle drop, re-grant
    capture("handshake", 1, 8'h00, 8'h00, 5, 1'b0);
    capture("regrant", 0, 8'h0F, 8'h03, 0, 1'b0);

    // Abort after 3 capture strobes (P=2, T=N+1)
    div = DIV_W'(1);
    trig_mask = 8'h00;
    grant_acq = 1'b1;
    tick();
    n = ecnt;
    while (ecnt < n + 7) tick();
    grant_acq = 1'b0;
    tick();
    chk("abort.armed", armed, 0);
    chk("abort.done", done_acq, 0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done_acq) seen = 1'b1;
    end
    chk("abort.no_done", seen, 0);
    capture("after_abort", 0, 8'h00, 8'h00, 0, 1'b0);

    // Reset mid-capture
    probe = 8'h40;
    div = '0;
    trig_mask = 8'h00;
    rd_addr = '0;
    grant_acq = 1'b1;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    chk("rstmid.done", done_acq, 0);
    chk("rstmid.armed", armed, 0);
    chk("rstmid.rd_data", rd_data, 0);
    grant_acq = 1'b0;
    #1;
    rst_n = 1'b1;
    tick();
    chk("rstmid.idle_armed", armed, 0);
    chk("rstmid.idle_done", done_acq, 0);
    capture("after_rst", 2, 8'h00, 8'h00, 2, 1'b1);

    // Randomised probe, divider and sparse trigger masks
    pmode = 1;
    for (int r = 0; r < 5; r++) begin
      capture($sformatf("rand%0d", r), int'($urandom_range(0, 3)),
              8'(1 << $urandom_range(0, 7)), 8'($urandom),
              int'($urandom_range(0, 3)), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/sample_capture.md
# sample_capture

Acquisition stage of the logic analyser, driven directly by the task dispatcher. While the dispatcher holds `grant_acq`, the block does three things: synchronises the 8-bit probe bus, waits for a masked trigger pattern, and records a fixed number of divided-rate samples into an internal buffer. It then raises `done_acq`. The transmit stage reads the buffer back through a synchronous read port after the dispatcher switches to `grant_txd`.

## Interface
- `DEPTH`, 256: samples per capture; power of two, 2..4096.
- `AW`, 8: address width, equal to log2(DEPTH).
- `DIV_W`, 16: width of the sample-rate divider.
- `clk` input 1: system clock; all logic on its rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `grant_acq` input 1: level; the dispatcher grants acquisition.
- `probe` input 8: asynchronous logic-analyser inputs.
- `div` input DIV_W: sample period minus 1, in clk cycles; held static during a capture.
- `trig_mask` input 8: 1 means the bit takes part in trigger compare.
- `trig_value` input 8: required level of each masked bit.
- `done_acq` output 1: registered level; capture complete.
- `armed` output 1: registered; waiting for trigger (LED).
- `rd_addr` input AW: buffer read address, from the transmit stage.
- `rd_data` output 8: buffer read data, registered, 1-cycle latency.

## Operation
- Probe path: 2-flop synchroniser gives `probe_s`. The synchroniser does not reset.
- Prescaler: a counter counts down from `div` to 0. A `strobe` pulses when it reaches 0, then the counter reloads `div`. `div`=0 gives a strobe every cycle. The counter is forced to 0 on entry to ARM, so the first strobe lands in the first ARM cycle.
- Trigger match: `(probe_s & trig_mask) == (trig_value & trig_mask)`. `trig_mask`=0 means an immediate trigger.
- FSM states and transitions:
  - IDLE: `grant_acq`=1 goes to ARM.
  - ARM: `strobe` with a trigger match writes `probe_s` to address 0, sets `wr_ptr`=1, and goes to CAPTURE. `strobe` without a match stays in ARM.
  - CAPTURE: each `strobe` writes `probe_s` to `wr_ptr` and increments it. The write to address DEPTH-1 goes to DONE.
  - DONE: `done_acq`=1 and the buffer is frozen. `grant_acq`=0 returns to IDLE.
  - In ARM or CAPTURE, `grant_acq`=0 aborts to IDLE. There is no `done_acq`, and the buffer contents are undefined.
- `wr_ptr` is AW bits. The final write wraps it to 0, which is harmless because no writes occur outside ARM/CAPTURE.
- Read port: `rd_data` returns mem[`rd_addr`] one cycle later, in every state. A simultaneous read and write to the same address returns the old data.
- Reset: state=IDLE, `done_acq`=0, `armed`=0, `wr_ptr`=0, prescaler=0, `rd_data`=0. Buffer contents are not reset.

## Timing
- `probe` to `probe_s`: 2 cycles.
- `grant_acq` sampled high at edge N: state=ARM and `armed`=1 after edge N.
- Trigger strobe at edge T: sample stored at address 0, and CAPTURE starts after T.
- Capture end: with period P=`div`+1, the last write occurs at edge T+(DEPTH-1)·P, and `done_acq`=1 after the same edge.
- `done_acq` stays high until the first edge that sees `grant_acq`=0. It is low after that edge. The dispatcher drops `grant_acq` for at least one cycle between grants, so a stale `done_acq` is never seen at the next grant.
- `grant_acq` re-asserted while in DONE (no gap) does nothing; the block stays in DONE.
- `rst_n` low at any time, including mid-capture: outputs go to their reset values immediately; release is synchronised externally.

## Structure
- Shared package `la_pkg` holds:
  - the state encoding (IDLE/ARM/CAPTURE/DONE, 2 bits);
  - the sample width constant `LA_SAMPLE_W`=8;
  - the default DEPTH and DIV_W.
- Sub-module `sample_ram`: simple dual-port RAM (DEPTH×8), with a write port on the capture side and a registered read port. It infers block RAM and has no reset.
- Prescaler, synchroniser, trigger compare and FSM live in `sample_capture`.

## Test plan
- Immediate trigger: `trig_mask`=0, `div`=0, `probe` increments each cycle, DEPTH=8 → after the grant, 8 consecutive values are stored at addr 0..7 and `done_acq` rises 8 cycles after `armed`.
- Pattern trigger: `trig_mask`=8'hF0, `trig_value`=8'hA0, `probe` steps 8'h00..8'hFF → `armed` stays high until `probe_s`=8'hA0; then addr 0=8'hA0 and addr 1=8'hA1.
- Divider: `div`=3, counting `probe`, DEPTH=8 → stored values differ by 4, and `done_acq` arrives 28 cycles after the trigger.
- Abort: drop `grant_acq` after 3 CAPTURE strobes → IDLE next cycle and `done_acq` never asserts. A new grant restarts at ARM with `wr_ptr`=0.
- Handshake: hold `grant_acq` 5 cycles after `done_acq`, then drop it for 1 cycle and re-grant → `done_acq` low after the drop edge, and a new capture completes correctly.
- Reset mid-capture: pulse `rst_n` low in CAPTURE → `done_acq`=0, `armed`=0 and `rd_data`=0 asynchronously; state is IDLE after release.
